// File: rtl/id_stage.sv
// Instruction decode stage: decodes one RV32 instruction per handshake into a
// registered control bundle, with load-use interlock and a saturating stall counter.
module id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          M_EXT_EN = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             mem_read_o,
    output logic             branch_o,
    output logic             jump_o,
    output logic             illegal_o,
    output logic [1:0]       mem_to_reg_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [2:0]       funct3_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_STORE  = 7'b0100011,
        OP_LOAD   = 7'b0000011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_DMEM = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_src_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [1:0]      mem_to_reg;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc;
    } bundle_t;

    opcode_e    opcode;
    logic [6:0] funct7;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic       accept;
    bundle_t    dec;

    logic             out_valid_q, out_valid_d;
    bundle_t          bundle_q, bundle_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign opcode = opcode_e'(instr_i[6:0]);
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec            = '0;
        dec.rd         = instr_i[11:7];
        dec.funct3     = instr_i[14:12];
        dec.rs1        = instr_i[19:15];
        dec.rs2        = instr_i[24:20];
        dec.pc         = pc_i;
        dec.mem_to_reg = WB_ALU;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (!M_EXT_EN && funct7 == 7'b0000001) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                end
            end
            OP_I: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.branch = 1'b1;
            end
            OP_STORE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_LOAD: begin
                use_rs1        = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = WB_DMEM;
            end
            OP_JALR, OP_JAL: begin
                use_rs1        = (opcode == OP_JALR);
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.mem_to_reg = WB_PC4;
            end
            OP_AUIPC: dec.reg_write = 1'b1;
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = WB_IMM;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Interlock against a load still in EX whose result this instruction reads.
    always_comb begin
        hazard = in_valid_i && ex_load_i && (ex_rd_i != '0) &&
                 ((use_rs1 && dec.rs1 == ex_rd_i) || (use_rs2 && dec.rs2 == ex_rd_i));
        in_ready_o = rst_ni && (!out_valid_q || out_ready_i) && !hazard && !flush_i;
        accept     = in_valid_i && in_ready_o;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (hazard && !flush_i && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign reg_write_o  = bundle_q.reg_write;
    assign mem_write_o  = bundle_q.mem_write;
    assign mem_read_o   = bundle_q.mem_read;
    assign branch_o     = bundle_q.branch;
    assign jump_o       = bundle_q.jump;
    assign illegal_o    = bundle_q.illegal;
    assign mem_to_reg_o = bundle_q.mem_to_reg;
    assign rd_o         = bundle_q.rd;
    assign rs1_o        = bundle_q.rs1;
    assign rs2_o        = bundle_q.rs2;
    assign funct3_o     = bundle_q.funct3;
    assign pc_o         = bundle_q.pc;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: two instances (M on / 16-bit counter, M off / 2-bit
// counter) share one stimulus stream and are checked against a rule-level model.
module tb_id_stage;

    typedef struct packed {
        logic        rw, mw, mr, br, jp, il;
        logic [1:0]  m2r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] pc;
    } dec_t;

    typedef struct {
        dec_t a;
        dec_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, ex_load = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0, pc = '0;
    logic [4:0]  ex_rd = '0;

    logic        a_in_ready, a_out_valid, a_rw, a_mw, a_mr, a_br, a_jp, a_il;
    logic [1:0]  a_m2r;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3;
    logic [31:0] a_pc;
    logic [15:0] a_stall;
    logic        b_in_ready, b_out_valid, b_rw, b_mw, b_mr, b_br, b_jp, b_il;
    logic [1:0]  b_m2r;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3;
    logic [31:0] b_pc;
    logic [1:0]  b_stall;

    dec_t a_act, b_act;
    assign a_act = {a_rw, a_mw, a_mr, a_br, a_jp, a_il, a_m2r, a_rd, a_rs1, a_rs2, a_f3, a_pc};
    assign b_act = {b_rw, b_mw, b_mr, b_br, b_jp, b_il, b_m2r, b_rd, b_rs1, b_rs2, b_f3, b_pc};

    int   n_tests = 0;
    int   n_fail = 0;
    int   rst_pulses = 0;
    int   m_stall = 0;
    bit   m_valid = 1'b0;
    exp_t exp_q[$];

    id_stage #(.XLEN(32), .M_EXT_EN(1'b1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .reg_write_o(a_rw), .mem_write_o(a_mw), .mem_read_o(a_mr), .branch_o(a_br),
        .jump_o(a_jp), .illegal_o(a_il), .mem_to_reg_o(a_m2r), .rd_o(a_rd),
        .rs1_o(a_rs1), .rs2_o(a_rs2), .funct3_o(a_f3), .pc_o(a_pc), .stall_cnt_o(a_stall)
    );

    id_stage #(.XLEN(32), .M_EXT_EN(1'b0), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_load_i(ex_load), .ex_rd_i(ex_rd),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready),
        .reg_write_o(b_rw), .mem_write_o(b_mw), .mem_read_o(b_mr), .branch_o(b_br),
        .jump_o(b_jp), .illegal_o(b_il), .mem_to_reg_o(b_m2r), .rd_o(b_rd),
        .rs1_o(b_rs1), .rs2_o(b_rs2), .funct3_o(b_f3), .pc_o(b_pc), .stall_cnt_o(b_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dec(input string tag, input dec_t act, input dec_t exp);
        chk({tag, ".reg_write"},  64'(act.rw),  64'(exp.rw));
        chk({tag, ".mem_write"},  64'(act.mw),  64'(exp.mw));
        chk({tag, ".mem_read"},   64'(act.mr),  64'(exp.mr));
        chk({tag, ".branch"},     64'(act.br),  64'(exp.br));
        chk({tag, ".jump"},       64'(act.jp),  64'(exp.jp));
        chk({tag, ".illegal"},    64'(act.il),  64'(exp.il));
        chk({tag, ".mem_to_reg"}, 64'(act.m2r), 64'(exp.m2r));
        chk({tag, ".rd"},         64'(act.rd),  64'(exp.rd));
        chk({tag, ".rs1"},        64'(act.rs1), 64'(exp.rs1));
        chk({tag, ".rs2"},        64'(act.rs2), 64'(exp.rs2));
        chk({tag, ".funct3"},     64'(act.f3),  64'(exp.f3));
        chk({tag, ".pc"},         64'(act.pc),  64'(exp.pc));
    endtask

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] p, input bit mext);
        dec_t       d;
        logic [6:0] op;
        bit         legal;
        op    = ins[6:0];
        d     = '0;
        d.rd  = ins[11:7];
        d.f3  = ins[14:12];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.pc  = p;
        legal = op inside {7'h33, 7'h13, 7'h63, 7'h23, 7'h03, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h0F, 7'h73};
        if (op == 7'h33 && ins[31:25] == 7'h01 && !mext) legal = 1'b0;
        d.il = !legal;
        if (legal) begin
            d.rw  = !(op inside {7'h63, 7'h23, 7'h0F, 7'h73});
            d.mw  = (op == 7'h23);
            d.mr  = (op == 7'h03);
            d.br  = (op == 7'h63);
            d.jp  = op inside {7'h67, 7'h6F};
            d.m2r = d.mr ? 2'd1 : d.jp ? 2'd2 : (op == 7'h37) ? 2'd3 : 2'd0;
        end
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [6:0] op;
        logic [6:0] f7;
        int unsigned k;
        ops = '{7'h33, 7'h13, 7'h63, 7'h23, 7'h03, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h0F, 7'h73};
        k   = $urandom_range(0, 12);
        op  = (k < 11) ? ops[k] : 7'($urandom);
        k   = $urandom_range(0, 2);
        f7  = (k == 0) ? 7'h00 : (k == 1) ? 7'h01 : 7'h20;
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom), op};
    endfunction

    // Reference model: decides readiness and acceptance each cycle from the rules.
    initial begin : model
        int  seen = 0;
        bit  hz, rdy;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_pulses != seen) begin
                seen    = rst_pulses;
                m_valid = 1'b0;
                m_stall = 0;
            end
            if (!rst_n) begin
                m_valid = 1'b0;
                m_stall = 0;
                chk("in_ready_a.rst", 64'(a_in_ready), 64'd0);
                chk("in_ready_b.rst", 64'(b_in_ready), 64'd0);
            end else begin
                hz  = in_valid && ex_load && ex_rd != 5'd0 &&
                      ((uses_rs1(instr[6:0]) && instr[19:15] == ex_rd) ||
                       (uses_rs2(instr[6:0]) && instr[24:20] == ex_rd));
                rdy = (!m_valid || out_ready) && !hz && !flush;
                chk("in_ready_a", 64'(a_in_ready), 64'(rdy));
                chk("in_ready_b", 64'(b_in_ready), 64'(rdy));
                if (in_valid && rdy) begin
                    e.a = ref_decode(instr, pc, 1'b1);
                    e.b = ref_decode(instr, pc, 1'b0);
                    exp_q.push_back(e);
                end
                if (hz && !flush) m_stall++;
                if (flush)                 m_valid = 1'b0;
                else if (in_valid && rdy)  m_valid = 1'b1;
                else if (out_ready)        m_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   vis = 1'b0;
        bit   pop;
        bit   rst_hit;
        int   seen = 0;
        int   exp_stall;
        dec_t cur_a = '0;
        dec_t cur_b = '0;
        exp_t drop;
        forever begin
            @(negedge clk);
            pop = vis && (out_ready || flush);
            @(posedge clk);
            #1;
            rst_hit = !rst_n || (rst_pulses != seen);
            seen    = rst_pulses;
            if (rst_hit) begin
                exp_q.delete();
                cur_a = '0;
                cur_b = '0;
            end else if (pop && exp_q.size() != 0) begin
                drop = exp_q.pop_front();
            end
            vis = (exp_q.size() != 0);
            if (vis) begin
                cur_a = exp_q[0].a;
                cur_b = exp_q[0].b;
            end
            chk("a.out_valid", 64'(a_out_valid), 64'(vis));
            chk("b.out_valid", 64'(b_out_valid), 64'(vis));
            cmp_dec("a", a_act, cur_a);
            cmp_dec("b", b_act, cur_b);
            exp_stall = rst_hit ? 0 : m_stall;
            chk("a.stall_cnt", 64'(a_stall), 64'((exp_stall > 65535) ? 65535 : exp_stall));
            chk("b.stall_cnt", 64'(b_stall), 64'((exp_stall > 3) ? 3 : exp_stall));
        end
    end

    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p, input bit fl,
                        input bit el, input logic [4:0] er, input bit ordy);
        in_valid  = v;
        instr     = ins;
        pc        = p;
        flush     = fl;
        ex_load   = el;
        ex_rd     = er;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lui x1
        step(1, 32'h123450B7, 32'h100, 0, 0, 0, 1);
        chk("lui.valid", 64'(a_out_valid), 64'd1);
        chk("lui.reg_write", 64'(a_rw), 64'd1);
        chk("lui.mem_to_reg", 64'(a_m2r), 64'd3);
        chk("lui.rd", 64'(a_rd), 64'd1);
        chk("lui.pc", 64'(a_pc), 64'h100);

        // lw x2 under backpressure
        step(1, 32'h0000A103, 32'h104, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 32'h0, 0, 0, 0, 0);
            chk("bp.valid", 64'(a_out_valid), 64'd1);
            chk("bp.in_ready", 64'(a_in_ready), 64'd0);
            chk("bp.mem_read", 64'(a_mr), 64'd1);
            chk("bp.mem_to_reg", 64'(a_m2r), 64'd1);
        end
        step(0, 32'h0, 32'h0, 0, 0, 0, 1);
        chk("bp.released", 64'(a_out_valid), 64'd0);

        // load-use on add x3,x1,x2
        step(1, 32'h002081B3, 32'h108, 0, 1, 2, 1);
        chk("lu.in_ready1", 64'(a_in_ready), 64'd0);
        step(1, 32'h002081B3, 32'h108, 0, 1, 2, 1);
        chk("lu.stall", 64'(a_stall), 64'd2);
        chk("lu.no_accept", 64'(a_out_valid), 64'd0);
        step(1, 32'h002081B3, 32'h108, 0, 0, 2, 1);
        chk("lu.accepted", 64'(a_out_valid), 64'd1);
        chk("lu.rd", 64'(a_rd), 64'd3);

        repeat (5) step(1, 32'h002081B3, 32'h10C, 0, 1, 2, 1);
        chk("sat.b_stall", 64'(b_stall), 64'd3);
        chk("sat.a_stall", 64'(a_stall), 64'd7);

        // mul: legal only with the M extension
        step(1, 32'h022081B3, 32'h110, 0, 0, 0, 1);
        chk("mul.a_illegal", 64'(a_il), 64'd0);
        chk("mul.a_reg_write", 64'(a_rw), 64'd1);
        chk("mul.b_illegal", 64'(b_il), 64'd1);
        chk("mul.b_reg_write", 64'(b_rw), 64'd0);
        step(1, 32'h0000007F, 32'h114, 0, 0, 0, 1);
        chk("op7f.a_illegal", 64'(a_il), 64'd1);
        chk("op7f.b_illegal", 64'(b_il), 64'd1);
        chk("op7f.valid", 64'(a_out_valid), 64'd1);

        // flush of a held bundle
        step(1, 32'h00100093, 32'h118, 0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0);
        step(1, 32'h00100093, 32'h11C, 1, 0, 0, 0);
        chk("flush.valid", 64'(a_out_valid), 64'd0);

        // asynchronous reset pulse between edges
        step(1, 32'h00100093, 32'h120, 0, 0, 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rst_pulses++;
        #1;
        chk("arst.valid", 64'(a_out_valid), 64'd0);
        chk("arst.in_ready", 64'(a_in_ready), 64'd0);
        chk("arst.stall", 64'(a_stall), 64'd0);
        cmp_dec("arst.a", a_act, '0);
        cmp_dec("arst.b", b_act, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'h123450B7, 32'h200, 0, 0, 0, 1);
        chk("post_rst.valid", 64'(a_out_valid), 64'd1);
        chk("post_rst.pc", 64'(a_pc), 64'h200);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        repeat (3) step(0, 32'h0, 32'h0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have a parameter XLEN, default 32, giving the PC width.
REQ-002 The block SHALL have a parameter M_EXT_EN, default 1; when 1, the M extension (R-type with funct7=0000001) is legal.
REQ-003 The block SHALL have a parameter CNT_W, default 16, giving the stall-counter width.
REQ-004 The ports SHALL be as follows; reset is asynchronous and active-low, with one clock:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  fetch offers an instruction
- in_ready_o  out  1  stage accepts this cycle
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- flush_i  in  1  discard held and offered instruction
- ex_load_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  EX destination register
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  EX accepts bundle
- reg_write_o, mem_write_o, mem_read_o, branch_o, jump_o, illegal_o  out  1 each  decoded controls
- mem_to_reg_o  out  2  writeback source: 00 ALU, 01 DMEM, 10 PC+4, 11 IMM
- rd_o, rs1_o, rs2_o  out  5 each  register fields
- funct3_o  out  3  funct3 field
- pc_o  out  XLEN  registered PC
- stall_cnt_o  out  CNT_W  saturating load-use stall count

Function
REQ-005 Decode by opcode SHALL be as follows; all unlisted controls are 0:
- 0110011 R: reg_write=1, src ALU.
- 0010011 I: reg_write=1, src ALU.
- 1100011: branch=1.
- 0100011: mem_write=1.
- 0000011: reg_write=1, mem_read=1, src DMEM.
- 1100111 and 1101111: reg_write=1, jump=1, src PC+4.
- 0010111: reg_write=1, src ALU.
- 0110111: reg_write=1, src IMM.
- 0001111 and 1110011: legal, no writes.
REQ-006 Any other opcode, or R-type with funct7=0000001 while M_EXT_EN=0, SHALL decode with illegal=1, all write/read/branch/jump controls 0, and src 00; the bundle is still delivered with out_valid_o=1.
REQ-007 An instruction SHALL use rs1 for R, I, load, store, branch, and jalr opcodes, and SHALL use rs2 for R, store, and branch opcodes.
REQ-008 A hazard SHALL be defined as in_valid_i && ex_load_i && ex_rd_i!=0 && (rs1 used and rs1==ex_rd_i, or rs2 used and rs2==ex_rd_i).
REQ-009 in_ready_o SHALL be combinational: (!out_valid_o || out_ready_i) && !hazard && !flush_i.
REQ-010 Accept SHALL be in_valid_i && in_ready_o; on accept, all decoded outputs, the register fields, funct3_o, and pc_o SHALL load at the next edge and out_valid_o SHALL become 1, giving one cycle of latency.
REQ-011 When out_ready_i=1, out_valid_o=1, and there is no accept, out_valid_o SHALL become 0 (bubble); all other outputs SHALL hold.
REQ-012 When out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable until a handshake occurs.
REQ-013 When flush_i=1, out_valid_o SHALL become 0 at the next edge regardless of other inputs, and no instruction is accepted that cycle.
REQ-014 For each cycle in which a hazard is present and flush_i=0, stall_cnt_o SHALL increment by 1, saturating at 2^CNT_W-1 without wrapping.
REQ-015 A hazard with out_ready_i=1 SHALL present a bubble (out_valid_o=0) at the next edge, and the offered instruction SHALL remain unaccepted.
REQ-016 Data outputs SHALL not be cleared when out_valid_o drops; consumers qualify all outputs with out_valid_o.

Reset
REQ-017 rst_ni=0 SHALL asynchronously force out_valid_o=0, every control output to 0, mem_to_reg_o=00, register fields, funct3_o, and pc_o to 0, and stall_cnt_o=0.
REQ-018 Reset deasserted mid-operation SHALL leave no pending bundle, and the first accept SHALL be possible in the first cycle after release.
REQ-019 in_ready_o SHALL be 0 while rst_ni=0.

Verification
REQ-020 Lui: offer instr 0x123450B7 with pc 0x100 and out_ready_i=1 -> next cycle out_valid_o=1, reg_write_o=1, mem_to_reg_o=11, rd_o=1, pc_o=0x100.
REQ-021 Backpressure: accept lw 0x0000A103, then hold out_ready_i=0 for 3 cycles -> outputs stable, in_ready_o=0, and after release mem_read_o=1 and mem_to_reg_o=01 for exactly one handshake.
REQ-022 Load-use: with ex_load_i=1 and ex_rd_i=2, offer add 0x002081B3 for 2 cycles, then set ex_load_i=0 -> in_ready_o=0 for 2 cycles, stall_cnt_o=2, and the add is accepted in the third cycle.
REQ-023 Illegal/M: offer mul 0x022081B3 with M_EXT_EN=0 -> illegal_o=1 and reg_write_o=0; with M_EXT_EN=1 -> illegal_o=0 and reg_write_o=1; opcode 0x7F -> illegal_o=1.
REQ-024 Flush/reset: assert flush_i while a bundle is held -> out_valid_o=0 next cycle; pulse rst_ni low between clock edges -> all outputs immediately 0.
REQ-025 Saturation: with CNT_W=2, hold a hazard for 5 cycles -> stall_cnt_o=3.
